// File: rtl/shifter_adc_reader.sv
// shifter_adc_reader: Avalon-MM initiator that runs the ADC sequencer, waits for the sample-store IRQ,
// reads the result slots and streams each sample out.
module shifter_adc_reader #(
    parameter int NUM_SLOTS      = 2,
    parameter int SAMPLE_W       = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clock_clk,
    input  logic                reset_sink_reset_n,
    input  logic                enable,
    output logic                sequencer_csr_address,
    output logic                sequencer_csr_read,
    output logic                sequencer_csr_write,
    output logic [31:0]         sequencer_csr_writedata,
    input  logic [31:0]         sequencer_csr_readdata,
    output logic [6:0]          sample_store_csr_address,
    output logic                sample_store_csr_read,
    output logic                sample_store_csr_write,
    output logic [31:0]         sample_store_csr_writedata,
    input  logic [31:0]         sample_store_csr_readdata,
    input  logic                sample_store_irq_irq,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [5:0]          sample_slot,
    output logic                sample_valid,
    output logic                frame_done,
    output logic                timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [3:0] {IDLE, ARM, START, WAIT_IRQ, STOP, READ, CAPT, CLEAR, DONE} state_t;
    state_t state, state_nxt;
    logic [5:0] slot;
    logic [CW-1:0] cnt;
    logic timed_out, last_slot, unused;

    assign timed_out = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign last_slot = slot == 6'(NUM_SLOTS - 1);
    assign unused = ^{sequencer_csr_readdata, sample_store_csr_readdata};

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) state <= IDLE;
        else                     state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:     state_nxt = enable ? ARM : IDLE;
            ARM:      state_nxt = START;
            START:    state_nxt = WAIT_IRQ;
            WAIT_IRQ: state_nxt = sample_store_irq_irq ? READ : timed_out ? STOP : WAIT_IRQ;
            STOP:     state_nxt = IDLE;
            READ:     state_nxt = CAPT;
            CAPT:     state_nxt = last_slot ? CLEAR : READ;
            CLEAR:    state_nxt = DONE;
            DONE:     state_nxt = enable ? START : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Sample outputs are registered so sample_valid lines up with the captured data.
    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            slot         <= '0;
            cnt          <= '0;
            sample_data  <= '0;
            sample_slot  <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cnt          <= state == WAIT_IRQ ? cnt + 1'b1 : '0;
            sample_valid <= state == CAPT;
            if (state == IDLE && enable) timeout_err <= 1'b0;
            else if (state == WAIT_IRQ && !sample_store_irq_irq && timed_out) timeout_err <= 1'b1;
            if (state == WAIT_IRQ) slot <= '0;
            else if (state == CAPT && !last_slot) slot <= slot + 1'b1;
            if (state == CAPT) begin
                sample_data <= sample_store_csr_readdata[SAMPLE_W-1:0];
                sample_slot <= slot;
            end
        end
    end

    always_comb begin
        sequencer_csr_address      = 1'b0;
        sequencer_csr_read         = 1'b0;
        sequencer_csr_write        = state == START || state == STOP;
        sequencer_csr_writedata    = state == START ? 32'h3 : 32'h0;
        sample_store_csr_read      = state == READ;
        sample_store_csr_write     = state == ARM || state == CLEAR;
        sample_store_csr_address   = state == ARM ? 7'd64 : state == CLEAR ? 7'd65 : state == READ ? {1'b0, slot} : 7'd0;
        sample_store_csr_writedata = (state == ARM || state == CLEAR) ? 32'h1 : 32'h0;
        frame_done                 = state == DONE;
    end
endmodule
